// File: rtl/seq_arith_unit.sv
// Multi-cycle integer arithmetic unit: single-cycle ADD/SUB, shift-add MUL and restoring DIV.
// Signed MUL/DIV run on magnitudes, and the result signs are applied in FIX.
module seq_arith_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [1:0]       op_q;
  logic             sgn_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic             accept, short_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic             min_neg1;

  // A new request can land in the DONE cycle, so DONE counts as not busy.
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign short_op = !op[1] || ((op == OP_DIV) && (b == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) next_state = short_op ? S_FIX : S_PREP;
      end
      S_PREP: begin
        busy       = 1'b1;
        next_state = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) next_state = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (accept) next_state = short_op ? S_FIX : S_PREP;
        else        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  assign a_abs = a_neg ? -a_q : a_q;
  assign b_abs = b_neg ? -b_q : b_q;

  // acc_lo shifts out multiplier bits (MUL) or dividend bits (DIV) while acc_hi accumulates.
  assign mul_sum   = {1'b0, acc_hi} + ({1'b0, opnd} & {(WIDTH+1){acc_lo[0]}});
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opnd};
  assign rem_sub   = rem_shift[WIDTH-1:0] - opnd;

  assign prod_fix = (a_neg ^ b_neg) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
  assign rem_fix  = a_neg ? -acc_hi : acc_hi;

  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = {1'b0, a_q} - {1'b0, b_q};
  assign min_neg1 = sgn_q && (a_q == MIN_VAL) && (b_q == '1);

  // Results are written only on the FIX->DONE edge, so outputs never move while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_ADD;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op;
        sgn_q <= is_signed;
        a_q   <= a;
        b_q   <= b;
      end
      case (state)
        S_PREP: begin
          acc_hi <= '0;
          cnt    <= '0;
          if (op_q == OP_MUL) begin
            opnd   <= a_abs;
            acc_lo <= b_abs;
          end else begin
            opnd   <= b_abs;
            acc_lo <= a_abs;
          end
        end
        S_ITER: begin
          cnt <= cnt + CW'(1);
          if (op_q == OP_MUL) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else begin
            acc_hi <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
          end
        end
        S_FIX: begin
          case (op_q)
            OP_ADD: begin
              result_lo   <= add_sum[WIDTH-1:0];
              result_hi   <= '0;
              overflow    <= sgn_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                      (add_sum[WIDTH-1] != a_q[WIDTH-1]))
                                   : add_sum[WIDTH];
              div_by_zero <= 1'b0;
            end
            OP_SUB: begin
              result_lo   <= sub_diff[WIDTH-1:0];
              result_hi   <= '0;
              overflow    <= sgn_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (sub_diff[WIDTH-1] != a_q[WIDTH-1]))
                                   : sub_diff[WIDTH];
              div_by_zero <= 1'b0;
            end
            OP_MUL: begin
              result_lo   <= prod_fix[WIDTH-1:0];
              result_hi   <= prod_fix[2*WIDTH-1:WIDTH];
              overflow    <= sgn_q ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                                   : (prod_fix[2*WIDTH-1:WIDTH] != '0);
              div_by_zero <= 1'b0;
            end
            default: begin
              if (b_q == '0) begin
                result_lo   <= '1;
                result_hi   <= a_q;
                overflow    <= 1'b0;
                div_by_zero <= 1'b1;
              end else begin
                result_lo   <= quo_fix;
                result_hi   <= rem_fix;
                overflow    <= min_neg1;
                div_by_zero <= 1'b0;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit: a 4-bit instance for sweeps/directed cases,
// a 32-bit instance for randomized mixed traffic against an integer-arithmetic model.
module tb_seq_arith_unit;

  localparam int LIMIT = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s_start, s_sgn, s_busy, s_done, s_ovf, s_dbz;
  logic [1:0] s_op;
  logic [3:0] s_a, s_b, s_lo, s_hi;

  logic        w_start, w_sgn, w_busy, w_done, w_ovf, w_dbz;
  logic [1:0]  w_op;
  logic [31:0] w_a, w_b, w_lo, w_hi;

  int n_compared = 0;
  int n_mismatched = 0;

  seq_arith_unit #(.WIDTH(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .is_signed(s_sgn),
    .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .result_lo(s_lo),
    .result_hi(s_hi), .overflow(s_ovf), .div_by_zero(s_dbz)
  );

  seq_arith_unit #(.WIDTH(32)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(w_start), .op(w_op), .is_signed(w_sgn),
    .a(w_a), .b(w_b), .busy(w_busy), .done(w_done), .result_lo(w_lo),
    .result_hi(w_hi), .overflow(w_ovf), .div_by_zero(w_dbz)
  );

  // Reference: exact integer arithmetic in 64 bits, then range checks for overflow.
  function automatic void model(input int w, input logic [1:0] op, input logic sgn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic ovf, output logic dbz);
    longint va, vb, r, maxv, minv, q, rm;
    longint unsigned mask, ua, ub, up;
    mask = (64'd1 << w) - 64'd1;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    va = longint'(a);
    vb = longint'(b);
    if (sgn && a[w-1]) va = va - (longint'(1) << w);
    if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
    ua = 64'(a);
    ub = 64'(b);
    lo = '0; hi = '0; ovf = 1'b0; dbz = 1'b0;
    case (op)
      2'b00: begin
        r = va + vb;
        lo = 32'(r) & 32'(mask);
        ovf = sgn ? ((r > maxv) || (r < minv)) : (r > longint'(mask));
      end
      2'b01: begin
        r = va - vb;
        lo = 32'(r) & 32'(mask);
        ovf = sgn ? ((r > maxv) || (r < minv)) : (r < 0);
      end
      2'b10: begin
        if (sgn) begin
          r = va * vb;
          lo = 32'(r) & 32'(mask);
          hi = 32'(r >>> w) & 32'(mask);
          ovf = (r > maxv) || (r < minv);
        end else begin
          up = ua * ub;
          lo = 32'(up) & 32'(mask);
          hi = 32'(up >> w) & 32'(mask);
          ovf = up > mask;
        end
      end
      default: begin
        if (b == '0) begin
          lo = 32'(mask);
          hi = a;
          dbz = 1'b1;
        end else begin
          q = va / vb;
          rm = va % vb;
          lo = 32'(q) & 32'(mask);
          hi = 32'(rm) & 32'(mask);
          ovf = sgn && (q > maxv);
        end
      end
    endcase
  endfunction

  // Issues one narrow op and returns the number of edges from acceptance to done.
  task automatic issue_narrow(input logic [1:0] op, input logic sgn,
                              input logic [3:0] a, input logic [3:0] b, output int cycles);
    @(negedge clk);
    s_op = op; s_sgn = sgn; s_a = a; s_b = b; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cycles = 0;
    while (s_done !== 1'b1 && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_start = 1'b0; s_op = 2'b00; s_sgn = 1'b0; s_a = '0; s_b = '0;
    w_start = 1'b0; w_op = 2'b00; w_sgn = 1'b0; w_a = '0; w_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if ({s_busy, s_done, s_ovf, s_dbz} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_narrow_flags got=%b exp=0000", {s_busy, s_done, s_ovf, s_dbz});
    end
    n_compared++;
    if ({s_hi, s_lo} !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_narrow_result got=%h exp=00", {s_hi, s_lo});
    end
    n_compared++;
    if ({w_busy, w_done, w_ovf, w_dbz} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_wide_flags got=%b exp=0000", {w_busy, w_done, w_ovf, w_dbz});
    end
    n_compared++;
    if ({w_hi, w_lo} !== 64'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_wide_result got=%h exp=0", {w_hi, w_lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addsub_sweep();
    int cycles;
    logic [3:0] av, bv;
    logic [31:0] e_lo, e_hi;
    logic e_ovf, e_dbz;
    for (int o = 0; o < 2; o++) begin
      for (int sg = 0; sg < 2; sg++) begin
        for (int i = 0; i < 256; i++) begin
          av = 4'(i >> 4);
          bv = 4'(i);
          issue_narrow(2'(o), 1'(sg), av, bv, cycles);
          model(4, 2'(o), 1'(sg), {28'b0, av}, {28'b0, bv}, e_lo, e_hi, e_ovf, e_dbz);
          n_compared++;
          if (cycles !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL sweep_latency op=%0d sgn=%0d a=%h b=%h got=%0d exp=1", o, sg, av, bv, cycles);
          end
          n_compared++;
          if (s_lo !== e_lo[3:0]) begin
            n_mismatched++;
            $display("[TB] FAIL sweep_lo op=%0d sgn=%0d a=%h b=%h got=%h exp=%h", o, sg, av, bv, s_lo, e_lo[3:0]);
          end
          n_compared++;
          if (s_ovf !== e_ovf) begin
            n_mismatched++;
            $display("[TB] FAIL sweep_ovf op=%0d sgn=%0d a=%h b=%h got=%b exp=%b", o, sg, av, bv, s_ovf, e_ovf);
          end
        end
      end
    end
    issue_narrow(2'b00, 1'b1, 4'b0111, 4'b0001, cycles);
    n_compared++;
    if ({s_lo, s_ovf} !== {4'b1000, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL add_signed_ovf got lo=%b ovf=%b exp lo=1000 ovf=1", s_lo, s_ovf);
    end
    issue_narrow(2'b01, 1'b0, 4'b0010, 4'b0011, cycles);
    n_compared++;
    if ({s_lo, s_ovf} !== {4'b1111, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL sub_unsigned_borrow got lo=%b ovf=%b exp lo=1111 ovf=1", s_lo, s_ovf);
    end
  endtask

  task automatic test_mul();
    int cycles;
    issue_narrow(2'b10, 1'b0, 4'b1111, 4'b1111, cycles);
    n_compared++;
    if (cycles !== 6) begin
      n_mismatched++;
      $display("[TB] FAIL mul_latency got=%0d exp=6", cycles);
    end
    n_compared++;
    if ({s_hi, s_lo, s_ovf} !== {4'b1110, 4'b0001, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL mul_unsigned got hi=%b lo=%b ovf=%b exp hi=1110 lo=0001 ovf=1", s_hi, s_lo, s_ovf);
    end
    issue_narrow(2'b10, 1'b1, 4'b1111, 4'b0011, cycles);
    n_compared++;
    if ({s_hi, s_lo, s_ovf} !== {4'b1111, 4'b1101, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL mul_signed got hi=%b lo=%b ovf=%b exp hi=1111 lo=1101 ovf=0", s_hi, s_lo, s_ovf);
    end
  endtask

  task automatic test_div();
    int cycles;
    issue_narrow(2'b11, 1'b1, 4'b1001, 4'b0010, cycles);
    n_compared++;
    if ({s_lo, s_hi, s_ovf, s_dbz} !== {4'b1101, 4'b1111, 2'b00}) begin
      n_mismatched++;
      $display("[TB] FAIL div_signed got lo=%b hi=%b ovf=%b dbz=%b exp lo=1101 hi=1111 ovf=0 dbz=0", s_lo, s_hi, s_ovf, s_dbz);
    end
    issue_narrow(2'b11, 1'b1, 4'b1000, 4'b1111, cycles);
    n_compared++;
    if ({s_lo, s_hi, s_ovf} !== {4'b1000, 4'b0000, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL div_min_neg1 got lo=%b hi=%b ovf=%b exp lo=1000 hi=0000 ovf=1", s_lo, s_hi, s_ovf);
    end
    issue_narrow(2'b11, 1'b0, 4'b0101, 4'b0000, cycles);
    n_compared++;
    if (cycles !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL div_zero_latency got=%0d exp=1", cycles);
    end
    n_compared++;
    if ({s_lo, s_hi, s_ovf, s_dbz} !== {4'b1111, 4'b0101, 2'b01}) begin
      n_mismatched++;
      $display("[TB] FAIL div_zero got lo=%b hi=%b ovf=%b dbz=%b exp lo=1111 hi=0101 ovf=0 dbz=1", s_lo, s_hi, s_ovf, s_dbz);
    end
  endtask

  task automatic test_busy_ignore();
    int cycles;
    logic saw_idle;
    @(negedge clk);
    s_op = 2'b10; s_sgn = 1'b1; s_a = 4'b0010; s_b = 4'b0011; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cycles = 0;
    saw_idle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_busy !== 1'b1) saw_idle = 1'b1;
      s_op = 2'($urandom); s_sgn = 1'($urandom); s_a = 4'($urandom); s_b = 4'($urandom);
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      cycles++;
    end
    while (s_done !== 1'b1 && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_compared++;
    if (saw_idle !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ignore_busy got busy-drop=%b exp=0", saw_idle);
    end
    n_compared++;
    if (cycles !== 6) begin
      n_mismatched++;
      $display("[TB] FAIL ignore_latency got=%0d exp=6", cycles);
    end
    n_compared++;
    if ({s_hi, s_lo, s_ovf} !== {4'b0000, 4'b0110, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL ignore_result got hi=%b lo=%b ovf=%b exp hi=0000 lo=0110 ovf=0", s_hi, s_lo, s_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    issue_narrow(2'b00, 1'b0, 4'b0101, 4'b0110, cycles);
    n_compared++;
    if ({s_done, s_lo} !== {1'b1, 4'b1011}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first got done=%b lo=%b exp done=1 lo=1011", s_done, s_lo);
    end
    @(negedge clk);
    s_op = 2'b10; s_sgn = 1'b0; s_a = 4'b0011; s_b = 4'b0100; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n_compared++;
    if ({s_busy, s_done, s_lo} !== {1'b1, 1'b0, 4'b1011}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_accept got busy=%b done=%b lo=%b exp busy=1 done=0 lo=1011", s_busy, s_done, s_lo);
    end
    cycles = 0;
    while (s_done !== 1'b1 && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_compared++;
    if (cycles !== 6) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_latency got=%0d exp=6", cycles);
    end
    n_compared++;
    if ({s_hi, s_lo} !== {4'b0000, 4'b1100}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_second got hi=%b lo=%b exp hi=0000 lo=1100", s_hi, s_lo);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic saw_done;
    issue_narrow(2'b10, 1'b0, 4'b1111, 4'b1111, cycles);
    @(negedge clk);
    s_op = 2'b10; s_sgn = 1'b0; s_a = 4'b0111; s_b = 4'b0101; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({s_busy, s_done, s_ovf, s_dbz, s_hi, s_lo} !== 12'h000) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_clear got busy=%b done=%b ovf=%b dbz=%b hi=%b lo=%b exp all 0",
               s_busy, s_done, s_ovf, s_dbz, s_hi, s_lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (s_done === 1'b1) saw_done = 1'b1;
    end
    n_compared++;
    if (saw_done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_no_done got=%b exp=0", saw_done);
    end
    issue_narrow(2'b00, 1'b1, 4'b0011, 4'b0100, cycles);
    n_compared++;
    if ({cycles == 1, s_lo, s_ovf} !== {1'b1, 4'b0111, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_add got cycles=%0d lo=%b ovf=%b exp cycles=1 lo=0111 ovf=0", cycles, s_lo, s_ovf);
    end
  endtask

  task automatic test_random_wide();
    int cycles, exp_l, r, k;
    logic [1:0] op;
    logic sgn, unstable;
    logic [31:0] av, bv, e_lo, e_hi;
    logic e_ovf, e_dbz;
    logic [31:0] p_lo, p_hi;
    logic p_ovf, p_dbz;
    p_lo = '0; p_hi = '0; p_ovf = 1'b0; p_dbz = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      r = int'($urandom_range(0, 99));
      op = (r < 5) ? 2'b10 : (r < 10) ? 2'b11 : (r < 55) ? 2'b00 : 2'b01;
      sgn = 1'($urandom);
      av = $urandom;
      bv = $urandom;
      if (op == 2'b11) begin
        k = int'($urandom_range(0, 7));
        if (k == 0) bv = '0;
        else if (k == 1) begin
          av = 32'h8000_0000;
          bv = 32'hFFFF_FFFF;
        end
      end
      model(32, op, sgn, av, bv, e_lo, e_hi, e_ovf, e_dbz);
      exp_l = (!op[1] || (op == 2'b11 && bv == '0)) ? 1 : 34;
      @(negedge clk);
      w_op = op; w_sgn = sgn; w_a = av; w_b = bv; w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      cycles = 0;
      unstable = 1'b0;
      while (w_done !== 1'b1 && cycles < LIMIT) begin
        if (w_lo !== p_lo || w_hi !== p_hi || w_ovf !== p_ovf || w_dbz !== p_dbz || w_busy !== 1'b1)
          unstable = 1'b1;
        @(posedge clk); #1;
        cycles++;
      end
      n_compared++;
      if (cycles !== exp_l) begin
        n_mismatched++;
        $display("[TB] FAIL rand_latency op=%0d got=%0d exp=%0d", op, cycles, exp_l);
      end
      n_compared++;
      if (w_lo !== e_lo) begin
        n_mismatched++;
        $display("[TB] FAIL rand_lo op=%0d sgn=%0d a=%h b=%h got=%h exp=%h", op, sgn, av, bv, w_lo, e_lo);
      end
      n_compared++;
      if (w_hi !== e_hi) begin
        n_mismatched++;
        $display("[TB] FAIL rand_hi op=%0d sgn=%0d a=%h b=%h got=%h exp=%h", op, sgn, av, bv, w_hi, e_hi);
      end
      n_compared++;
      if ({w_ovf, w_dbz} !== {e_ovf, e_dbz}) begin
        n_mismatched++;
        $display("[TB] FAIL rand_flags op=%0d sgn=%0d a=%h b=%h got=%b exp=%b", op, sgn, av, bv, {w_ovf, w_dbz}, {e_ovf, e_dbz});
      end
      n_compared++;
      if (unstable !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL rand_hold op=%0d got=%b exp=0", op, unstable);
      end
      p_lo = e_lo; p_hi = e_hi; p_ovf = e_ovf; p_dbz = e_dbz;
    end
  endtask

  initial begin
    $display("[TB] starting seq_arith_unit bench");
    test_reset();
    test_addsub_sweep();
    test_mul();
    test_div();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
